// File: rtl/led_cube_pkg.sv
// Shared types and constants for the 6x36 LED cube layer scanner.
package led_cube_pkg;

    localparam int unsigned NUM_LAYERS  = 6;
    localparam int unsigned NUM_COLS    = 36;
    localparam int unsigned LAYER_IDX_W = 3;
    localparam int unsigned CNT_W       = 20;
    localparam int unsigned PWM_W       = 8;

    typedef logic [NUM_LAYERS-1:0]  layer_t;
    typedef logic [NUM_COLS-1:0]    col_t;
    typedef logic [LAYER_IDX_W-1:0] layer_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    localparam layer_idx_t LAST_LAYER = layer_idx_t'(NUM_LAYERS - 1);

    // One-hot layer select for a layer index.
    function automatic layer_t layer_onehot(input layer_idx_t idx);
        return layer_t'(1) << idx;
    endfunction

    // Indices 6 and 7 do not address a layer.
    function automatic logic layer_valid(input layer_idx_t idx);
        return idx <= LAST_LAYER;
    endfunction

endpackage

// File: rtl/led_cube_layer_scanner_if.sv
// Frame write and buffer-swap handshake between a pattern source and the scanner.
interface led_cube_layer_scanner_if;
    import led_cube_pkg::*;

    logic       wr_valid;
    layer_idx_t wr_layer;
    col_t       wr_data;
    logic       swap_req;
    logic       swap_ack;

    modport master (output wr_valid, wr_layer, wr_data, swap_req, input swap_ack);
    modport slave  (input wr_valid, wr_layer, wr_data, swap_req, output swap_ack);

endinterface

// File: rtl/led_cube_frame_bank.sv
// Double-buffered frame store: writes go to the back bank, reads come from the front bank.
module led_cube_frame_bank
    import led_cube_pkg::*;
(
    input  logic       clk,
    input  logic       wr_en_i,
    input  logic       wr_bank_i,
    input  layer_idx_t wr_layer_i,
    input  col_t       wr_data_i,
    input  logic       rd_bank_i,
    input  layer_idx_t rd_layer_i,
    output col_t       rd_data_c
);

    col_t mem_q [2][NUM_LAYERS];

    // Storage is intentionally not reset; out-of-range layer writes are dropped.
    always_ff @(posedge clk) begin
        if (wr_en_i && layer_valid(wr_layer_i)) begin
            mem_q[wr_bank_i][wr_layer_i] <= wr_data_i;
        end
    end

    assign rd_data_c = mem_q[rd_bank_i][rd_layer_i];

endmodule

// File: rtl/led_cube_layer_scanner.sv
// LED cube layer scanner: cycles six layers through BLANK/DRIVE with a
// double-buffered frame and swap at the end of layer 5.
// Optional build macro LED_CUBE_BRIGHTNESS_EN adds the bright input and
// 8-bit PWM gating of col_out.
module led_cube_layer_scanner
    import led_cube_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    led_cube_layer_scanner_if.slave        bus,
`ifdef LED_CUBE_BRIGHTNESS_EN
    input  logic [PWM_W-1:0]               bright,
`endif
    output logic                           frame_start,
    output col_t                           col_out,
    output layer_t                         layer_out
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    scan_state_t      state_q,       state_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    layer_idx_t       layer_idx_q,   layer_idx_d;
    logic             bank_sel_q,    bank_sel_d;
    logic             swap_pend_q,   swap_pend_d;
    logic             swap_ack_q,    swap_ack_d;
    logic             frame_start_q, frame_start_d;
    col_t             col_q,         col_d;
    layer_t           layer_q,       layer_d;
    logic             lit;
    col_t             front_c;
`ifdef LED_CUBE_BRIGHTNESS_EN
    logic [PWM_W-1:0] pwm_q,         pwm_d;
`endif

    led_cube_frame_bank u_bank (
        .clk        (clk),
        .wr_en_i    (bus.wr_valid),
        .wr_bank_i  (~bank_sel_q),
        .wr_layer_i (bus.wr_layer),
        .wr_data_i  (bus.wr_data),
        .rd_bank_i  (bank_sel_q),
        .rd_layer_i (layer_idx_q),
        .rd_data_c  (front_c)
    );

    // Next-state and next-output logic for the scan FSM.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_W'(1);
        layer_idx_d   = layer_idx_q;
        bank_sel_d    = bank_sel_q;
        swap_pend_d   = swap_pend_q | bus.swap_req;
        swap_ack_d    = 1'b0;
        frame_start_d = 1'b0;
        col_d         = '0;
        layer_d       = '0;
        lit           = 1'b0;

        if (!enable) begin
            state_d     = IDLE;
            cnt_d       = '0;
            layer_idx_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d       = DRIVE;
                        cnt_d         = '0;
                        lit           = 1'b1;
                        frame_start_d = (layer_idx_q == '0);
                    end
                end
                DRIVE: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (layer_idx_q == LAST_LAYER) begin
                            layer_idx_d = '0;
                            // A request arriving this very cycle is folded into swap_pend_d.
                            if (swap_pend_d) begin
                                bank_sel_d  = ~bank_sel_q;
                                swap_pend_d = 1'b0;
                                swap_ack_d  = 1'b1;
                            end
                        end else begin
                            layer_idx_d = layer_idx_q + layer_idx_t'(1);
                        end
                    end else begin
                        lit = 1'b1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    layer_idx_d = '0;
                end
            endcase
        end

        if (lit) begin
            layer_d = layer_onehot(layer_idx_q);
            col_d   = front_c;
        end

`ifdef LED_CUBE_BRIGHTNESS_EN
        // PWM phase restarts on DRIVE entry so every layer gets the same duty window.
        pwm_d = (enable && (state_q == BLANK) && (cnt_q == BLANK_LAST)) ? '0 : pwm_q + PWM_W'(1);
        if (pwm_d >= bright) begin
            col_d = '0;
        end
`endif
    end

    // State, counters, bank select and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            layer_idx_q   <= '0;
            bank_sel_q    <= 1'b0;
            swap_pend_q   <= 1'b0;
            swap_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            col_q         <= '0;
            layer_q       <= '0;
`ifdef LED_CUBE_BRIGHTNESS_EN
            pwm_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            layer_idx_q   <= layer_idx_d;
            bank_sel_q    <= bank_sel_d;
            swap_pend_q   <= swap_pend_d;
            swap_ack_q    <= swap_ack_d;
            frame_start_q <= frame_start_d;
            col_q         <= col_d;
            layer_q       <= layer_d;
`ifdef LED_CUBE_BRIGHTNESS_EN
            pwm_q         <= pwm_d;
`endif
        end
    end

    assign bus.swap_ack = swap_ack_q;
    assign frame_start  = frame_start_q;
    assign col_out      = col_q;
    assign layer_out    = layer_q;

endmodule

// File: tb/tb_led_cube_layer_scanner.sv
// Scoreboard bench for led_cube_layer_scanner with DWELL=8, BLANK=2.
module tb_led_cube_layer_scanner;
    import led_cube_pkg::*;

    localparam int T_DWELL = 8;
    localparam int T_BLANK = 2;

    localparam col_t PAT_A [6] = '{36'h000000001, 36'h000000F00, 36'h0000AA000,
                                   36'h00C300000, 36'h5A0000000, 36'h800000001};
    localparam col_t PAT_B [6] = '{36'h111111111, 36'h222222222, 36'hF0F0F0F0F,
                                   36'h333333333, 36'h444444444, 36'h555555555};
    localparam col_t PAT_C5    = 36'hABCDEF012;
    localparam col_t ONES      = 36'hFFFFFFFFF;

    typedef struct {
        layer_t layer;
        col_t   col;
        bit     chk_col;
        bit     fs;
        int     len;
        int     gap;
        bit     ack;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset_n = 1'b0;
    logic   enable = 1'b0;
    logic   frame_start;
    col_t   col_out;
    layer_t layer_out;
`ifdef LED_CUBE_BRIGHTNESS_EN
    logic [7:0] bright = 8'd255;
`endif

    led_cube_layer_scanner_if bus ();

    led_cube_layer_scanner #(
        .DWELL_CYCLES (T_DWELL),
        .BLANK_CYCLES (T_BLANK)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .bus         (bus.slave),
`ifdef LED_CUBE_BRIGHTNESS_EN
        .bright      (bright),
`endif
        .frame_start (frame_start),
        .col_out     (col_out),
        .layer_out   (layer_out)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q [$];
    int   cur_e;
    bit   active = 1'b0;
    bit   in_seg = 1'b0;
    bit   have_cur = 1'b0;
    bit   ack_seen = 1'b0;
    int   seg_len = 0;
    int   gap = 0;
    int   ack_total = 0;
    exp_t cur;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic col_t pat(input int which, input int k);
        if (which == 1) return PAT_A[3'(k)];
        if (k == 5) return PAT_C5;
        return PAT_B[3'(k)];
    endfunction

    // which: 0 = contents not yet defined, 1 = bank of A, 2 = bank of B with layer 5 = C5
    task automatic push_frame(input int which, input bit ack0, input int gap0,
                              input int nlay, input int last_len);
        for (int k = 0; k < nlay; k++) begin
            exp_t e;
            e.layer   = 6'b000001 << k;
            e.col     = (which == 0) ? '0 : pat(which, k);
            e.chk_col = (which != 0);
            e.fs      = (k == 0);
            e.len     = (k == nlay - 1) ? last_len : T_DWELL;
            e.gap     = (k == 0) ? gap0 : T_BLANK;
            e.ack     = (k == 0) && ack0;
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cur_e++;
    endtask

    // Advance so that inputs set next are sampled at edge k.
    task automatic goto_edge(input int k);
        while (cur_e < k - 1) step();
    endtask

    task automatic write_at(input int k, input int layer, input col_t data);
        goto_edge(k);
        bus.wr_valid = 1'b1;
        bus.wr_layer = 3'(layer);
        bus.wr_data  = data;
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic swap_at(input int k);
        goto_edge(k);
        bus.swap_req = 1'b1;
        step();
        bus.swap_req = 1'b0;
    endtask

    // Monitor: segments of lit layer_out are matched against the expectation queue.
    always @(negedge clk) begin
        if (active) begin
            if (bus.swap_ack) begin
                ack_total++;
                ack_seen = 1'b1;
            end
            if (layer_out != '0) begin
                if (!in_seg) begin
                    in_seg  = 1'b1;
                    seg_len = 1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        have_cur = 1'b0;
                        $display("FAIL unexpected_segment: got layer_out %b expected none", layer_out);
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                        check("seg_layer", 64'(layer_out), 64'(cur.layer));
                        check("seg_frame_start", 64'(frame_start), 64'(cur.fs));
                        check("seg_gap", 64'(gap), 64'(cur.gap));
                        check("seg_swap_ack", 64'(ack_seen), 64'(cur.ack));
                        if (cur.chk_col) check("seg_col", 64'(col_out), 64'(cur.col));
                    end
                    ack_seen = 1'b0;
                    gap      = 0;
                end else begin
                    seg_len++;
                    check("lit_frame_start", 64'(frame_start), 64'(0));
                    if (have_cur) begin
                        check("lit_layer", 64'(layer_out), 64'(cur.layer));
                        if (cur.chk_col) check("lit_col", 64'(col_out), 64'(cur.col));
                    end
                end
            end else begin
                if (in_seg) begin
                    if (have_cur) check("seg_len", 64'(seg_len), 64'(cur.len));
                    in_seg = 1'b0;
                end
                check("dark_col", 64'(col_out), 64'(0));
                check("dark_frame_start", 64'(frame_start), 64'(0));
                gap = enable ? gap + 1 : 0;
            end
        end
    end

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_layer = '0;
        bus.wr_data  = '0;
        bus.swap_req = 1'b0;
        cur_e        = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_layer_out", 64'(layer_out), 64'(0));
        check("rst_col_out", 64'(col_out), 64'(0));
        check("rst_frame_start", 64'(frame_start), 64'(0));
        check("rst_swap_ack", 64'(bus.swap_ack), 64'(0));
        reset_n = 1'b1;
        active  = 1'b1;
        step();

        // Fill back bank 1 while disabled, plus an ignored layer-7 write, then request a swap.
        for (int k = 0; k < 6; k++) write_at(cur_e + 1, k, PAT_A[3'(k)]);
        write_at(cur_e + 1, 7, ONES);
        swap_at(cur_e + 1);

        push_frame(0, 1'b0, 3, 6, T_DWELL);   // bank 0 undefined
        push_frame(1, 1'b1, 2, 6, T_DWELL);   // swapped to A
        push_frame(1, 1'b0, 2, 6, T_DWELL);   // no request, still A
        push_frame(2, 1'b1, 2, 4, 3);         // swap to B; enable drops in layer 3
        push_frame(2, 1'b0, 3, 6, T_DWELL);   // restart from layer 0

        // Edge 0 is the first edge sampling enable high.
        enable = 1'b1;
        cur_e  = -1;

        swap_at(10);
        swap_at(30);
        for (int k = 0; k < 6; k++) write_at(70 + k, k, PAT_B[3'(k)]);
        write_at(76, 6, ONES);

        // Swap edge: late request taken, simultaneous write lands in the new front bank.
        goto_edge(180);
        bus.swap_req = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_layer = 3'd5;
        bus.wr_data  = PAT_C5;
        step();
        bus.swap_req = 1'b0;
        bus.wr_valid = 1'b0;

        goto_edge(215);
        enable = 1'b0;
        goto_edge(220);
        enable = 1'b1;
        goto_edge(281);
        enable = 1'b0;
        repeat (10) step();

        check("pending_expectations", 64'(exp_q.size()), 64'(0));
        check("swap_ack_total", 64'(ack_total), 64'(2));
        check("final_layer_out", 64'(layer_out), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
